param_datapath: RTL

// - Parametrised successor of the single-cycle processor datapath: register file + ALU + synchronous data memory + write-back mux.
// - Adds a one-op valid/ready issue port, a 1-stage EX/WB pipeline with hazard handling, and a post-reset register-file clear sweep.
// - Sits between the controller FSM (issues decoded ops) and the data RAM; the controller stalls on op_ready.

---
 rtl/param_datapath_pkg.sv | 39 +++
 rtl/dp_sync_ram.sv | 40 ++++
 rtl/param_datapath.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/param_datapath_pkg.sv
// ============================================================================
// Module      : param_datapath_pkg
// Description : Shared types for the parametrised datapath (op kinds, ALU
//               selects, sweep/run state).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package param_datapath_pkg;

    localparam int c_OP_KIND_W = 2;
    localparam int c_ALU_SEL_W = 3;

    typedef enum logic [c_OP_KIND_W-1:0] {
        OP_NOP   = 2'd0,
        OP_ALU   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_STORE = 2'd3
    } op_kind_t;

    typedef enum logic [c_ALU_SEL_W-1:0] {
        ALU_ZERO   = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_PASS_A = 3'd3,
        ALU_XOR    = 3'd4,
        ALU_OR     = 3'd5,
        ALU_AND    = 3'd6,
        ALU_INC    = 3'd7
    } alu_sel_t;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dp_sync_ram.sv
// ============================================================================
// Module      : dp_sync_ram
// Description : Simple dual-port data RAM, registered read; a read colliding
//               with a write to the same word returns the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_sync_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wren,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rden,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_q;

    // Non-blocking update gives read-old-data on a same-edge collision.
    always_ff @(posedge clk) begin
        if (wren) begin
            r_mem[waddr] <= wdata;
        end
        if (rden) begin
            r_q <= r_mem[raddr];
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/param_datapath.sv
// ============================================================================
// Module      : param_datapath
// Description : Register file + ALU + data RAM + write-back with a one-op
//               issue port, EX/WB stage and post-reset RF clear sweep.
//               Macro PARAM_DATAPATH_FORWARDING_EN selects bypass over interlock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_datapath
    import param_datapath_pkg::*;
#(
    parameter int DW       = 16,
    parameter int RF_DEPTH = 16,
    parameter int DM_DEPTH = 256,
    localparam int RAW     = $clog2(RF_DEPTH),
    localparam int DAW     = $clog2(DM_DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [1:0]     op_kind,
    input  logic [2:0]     alu_sel,
    input  logic [RAW-1:0] rd_addr,
    input  logic [RAW-1:0] ra_addr,
    input  logic [RAW-1:0] rb_addr,
    input  logic [DAW-1:0] d_addr,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic           wb_valid,
    output logic [RAW-1:0] wb_addr,
    output logic [DW-1:0]  wb_data,
    output logic           init_done
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [RAW-1:0] r_cnt;
    logic [RAW-1:0] w_cnt_nxt;
    logic           w_sweep_we;

    logic [DW-1:0]  r_rf [RF_DEPTH];
    logic [DW-1:0]  w_rf_a;
    logic [DW-1:0]  w_rf_b;

    logic           r_ex_valid;
    logic           r_ex_load;
    logic [RAW-1:0] r_ex_addr;
    logic [DW-1:0]  r_ex_alu;

    op_kind_t       w_kind;
    logic           w_stall;
    logic           w_accept;
    logic           w_ex_load;
    logic           w_to_ex;
    logic [DW-1:0]  w_alu_y;
    logic [DW-1:0]  w_ram_q;

    // ------------------------------------------------------------------
    // Sweep / run state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sweep_we  = 1'b0;
        case (r_state)
            INIT: begin
                w_sweep_we = 1'b1;
                w_cnt_nxt  = r_cnt + 1'b1;
                if (r_cnt == RAW'(RF_DEPTH - 1)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    assign init_done = (r_state == RUN);

    // ------------------------------------------------------------------
    // Issue handshake and operand selection
    // ------------------------------------------------------------------
    assign w_kind = op_kind_t'(op_kind);
    assign w_rf_a = r_rf[ra_addr];
    assign w_rf_b = r_rf[rb_addr];

`ifdef PARAM_DATAPATH_FORWARDING_EN
    assign alu_a   = (r_ex_valid && (ra_addr == r_ex_addr)) ? wb_data : w_rf_a;
    assign alu_b   = (r_ex_valid && (rb_addr == r_ex_addr)) ? wb_data : w_rf_b;
    assign w_stall = 1'b0;
`else
    logic w_use_a;
    logic w_use_b;

    assign w_use_a = (w_kind == OP_ALU) || (w_kind == OP_STORE);
    assign w_use_b = (w_kind == OP_ALU);
    assign alu_a   = w_rf_a;
    assign alu_b   = w_rf_b;
    // The EX stage always drains on a stall, so the hazard clears next cycle.
    assign w_stall = op_valid && r_ex_valid &&
                     ((w_use_a && (ra_addr == r_ex_addr)) ||
                      (w_use_b && (rb_addr == r_ex_addr)));
`endif

    assign op_ready  = (r_state == RUN) && !w_stall;
    assign w_accept  = op_valid && op_ready;
    assign w_ex_load = (w_kind == OP_LOAD);
    assign w_to_ex   = w_accept && ((w_kind == OP_ALU) || w_ex_load);

    // ------------------------------------------------------------------
    // ALU (wraps modulo 2^DW)
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_y = '0;
        case (alu_sel_t'(alu_sel))
            ALU_ZERO:   w_alu_y = '0;
            ALU_ADD:    w_alu_y = alu_a + alu_b;
            ALU_SUB:    w_alu_y = alu_a - alu_b;
            ALU_PASS_A: w_alu_y = alu_a;
            ALU_XOR:    w_alu_y = alu_a ^ alu_b;
            ALU_OR:     w_alu_y = alu_a | alu_b;
            ALU_AND:    w_alu_y = alu_a & alu_b;
            ALU_INC:    w_alu_y = alu_a + DW'(1);
            default:    w_alu_y = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Data memory; stores complete at their accept edge
    // ------------------------------------------------------------------
    dp_sync_ram #(
        .DW    (DW),
        .DEPTH (DM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .wren  (w_accept && (w_kind == OP_STORE) && !reset),
        .waddr (d_addr),
        .wdata (alu_a),
        .rden  (w_accept && w_ex_load),
        .raddr (d_addr),
        .q     (w_ram_q)
    );

    // ------------------------------------------------------------------
    // EX/WB stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid <= 1'b0;
            r_ex_load  <= 1'b0;
            r_ex_addr  <= '0;
            r_ex_alu   <= '0;
        end else begin
            r_ex_valid <= w_to_ex;
            if (w_to_ex) begin
                r_ex_load <= w_ex_load;
                r_ex_addr <= rd_addr;
                r_ex_alu  <= w_alu_y;
            end
        end
    end

    assign wb_valid = r_ex_valid;
    assign wb_addr  = r_ex_addr;
    assign wb_data  = r_ex_load ? w_ram_q : r_ex_alu;

    // A write pending at a reset edge is dropped; the sweep then rewrites all.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_sweep_we) begin
                r_rf[r_cnt] <= '0;
            end else if (r_ex_valid) begin
                r_rf[r_ex_addr] <= wb_data;
            end
        end
    end

endmodule

`default_nettype wire
